rsv_mem_arbiter: RTL and testbench

- Shares a single-ported unified instruction/data memory between the fetch stage (IF port) and the load/store unit (D port) of the RV32I core.
- Grants one transaction at a time; only one transaction is outstanding.
- Data accesses have priority. A bounded-burst rule keeps fetch from starving.
- Sits between the core and the memory wrapper; the fetch request/address path and the LSU path connect here instead of directly to memory.

---
 rtl/rsv_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_rsv_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsv_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (IF) and LSU (D) ports.
// Define RSV_ARB_PERF_CNT_EN to add saturating wait/transaction performance counters.
module rsv_mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
`ifdef RSV_ARB_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
`ifdef RSV_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] if_wait_cnt_o,
    output logic [CNT_W-1:0] d_wait_cnt_o,
    output logic [CNT_W-1:0] xact_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_D_BURST);

    state_e     state_q, state_d;
    logic       owner_if_q, owner_if_d;  // 1 = IF owns the transaction, 0 = D
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       arb_en;
    logic       pick_if;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            owner_if_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // IF only yields to D until D has taken MAX_D_BURST grants in a row while IF waited.
    assign arb_en  = (state_q == StIdle) || ((state_q == StRsp) && mem_rvalid_i);
    assign pick_if = if_req_i && (!d_req_i || (burst_cnt_q == MaxBurst));

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle:  state_d = StIdle;
            StReq:   if (mem_gnt_i) state_d = StRsp;
            StRsp:   if (mem_rvalid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (arb_en) begin
            if (if_req_i || d_req_i) begin
                state_d    = StReq;
                owner_if_d = pick_if;
            end
            if (if_req_i && !pick_if) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        unique case (state_q)
            StReq: begin
                mem_req_o = 1'b1;
                if (owner_if_q) begin
                    mem_be_o   = 4'hF;
                    mem_addr_o = if_addr_i;
                    if_gnt_o   = mem_gnt_i;
                end else begin
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                    d_gnt_o     = mem_gnt_i;
                end
            end
            StRsp: begin
                if (mem_rvalid_i) begin
                    if (owner_if_q) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end else begin
                        d_rvalid_o = 1'b1;
                        d_rdata_o  = mem_rdata_i;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef RSV_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] if_wait_cnt_q, d_wait_cnt_q, xact_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_wait_cnt_q <= '0;
            d_wait_cnt_q  <= '0;
            xact_cnt_q    <= '0;
        end else begin
            if (if_req_i && !if_gnt_o && !(&if_wait_cnt_q)) begin
                if_wait_cnt_q <= if_wait_cnt_q + CNT_W'(1);
            end
            if (d_req_i && !d_gnt_o && !(&d_wait_cnt_q)) begin
                d_wait_cnt_q <= d_wait_cnt_q + CNT_W'(1);
            end
            if ((if_rvalid_o || d_rvalid_o) && !(&xact_cnt_q)) begin
                xact_cnt_q <= xact_cnt_q + CNT_W'(1);
            end
        end
    end

    assign if_wait_cnt_o = if_wait_cnt_q;
    assign d_wait_cnt_o  = d_wait_cnt_q;
    assign xact_cnt_o    = xact_cnt_q;
`endif

endmodule

// File: tb/tb_rsv_mem_arbiter.sv
// Randomized bench for rsv_mem_arbiter with a transaction-level reference model.
// Perf counter checks are compiled in when RSV_ARB_PERF_CNT_EN is defined.
module tb_rsv_mem_arbiter;

    localparam int unsigned MaxDBurst = 4;

    logic        clk;
    logic        reset_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef RSV_ARB_PERF_CNT_EN
    logic [15:0] if_wait_cnt_o, d_wait_cnt_o, xact_cnt_o;
    logic [15:0] m_if_wait, m_d_wait, m_xact;
`endif

    rsv_mem_arbiter #(
        .MAX_D_BURST(MaxDBurst)
`ifdef RSV_ARB_PERF_CNT_EN
        ,
        .CNT_W(16)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef RSV_ARB_PERF_CNT_EN
        ,
        .if_wait_cnt_o(if_wait_cnt_o), .d_wait_cnt_o(d_wait_cnt_o), .xact_cnt_o(xact_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold request and fields until granted.
    a_if_hold: assert property (@(posedge clk) disable iff (!reset_n)
        if_req_i && !if_gnt_o |=> if_req_i && $stable(if_addr_i));
    a_d_hold: assert property (@(posedge clk) disable iff (!reset_n)
        d_req_i && !d_gnt_o |=> d_req_i && $stable({d_we_i, d_be_i, d_addr_i, d_wdata_i}));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked as picked / accepted by memory.
    bit m_busy, m_granted, m_own_if;
    int m_burst;
    bit last_if_gnt, last_d_gnt, last_rv;

    // Stimulus knobs
    int if_left, d_left, if_pct, d_pct, gnt_pct, dly_max, dly_fix, dly_cnt, gnt_hold, late_rv;
    bit noise, if_fix, d_fix, rd_fix_en;
    logic [31:0] if_fix_addr, d_fix_addr, d_fix_wdata, rd_fix;
    logic        d_fix_we;
    logic [3:0]  d_fix_be;

    // Observed DUT events since last reset
    int cyc, n_if_gnt, n_d_gnt, n_if_rv, n_d_rv;
    int if_gnt_cyc, if_rv_cyc, d_gnt_cyc, d_rv_cyc;
    logic [31:0] if_rv_data, seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    int gnt_log[$];

    function automatic logic [31:0] out_bits();
        logic any;
        any = mem_req_o | mem_we_o | (|mem_be_o) | (|mem_addr_o) | (|mem_wdata_o) | if_gnt_o
            | if_rvalid_o | (|if_rdata_o) | d_gnt_o | d_rvalid_o | (|d_rdata_o);
`ifdef RSV_ARB_PERF_CNT_EN
        any = any | (|if_wait_cnt_o) | (|d_wait_cnt_o) | (|xact_cnt_o);
`endif
        return 32'(any);
    endfunction

    task automatic clear_tb_state();
        m_busy = 0; m_granted = 0; m_own_if = 0; m_burst = 0;
        last_if_gnt = 0; last_d_gnt = 0; last_rv = 0;
        if_left = 0; d_left = 0; if_pct = 0; d_pct = 0; gnt_pct = 100; dly_max = 0;
        dly_fix = -1; dly_cnt = 0; gnt_hold = 0; late_rv = 0;
        noise = 0; if_fix = 0; d_fix = 0; rd_fix_en = 0;
        cyc = 0; n_if_gnt = 0; n_d_gnt = 0; n_if_rv = 0; n_d_rv = 0;
        if_gnt_cyc = -1; if_rv_cyc = -1; d_gnt_cyc = -1; d_rv_cyc = -1;
        if_rv_data = 0; seen_addr = 0; seen_wdata = 0; seen_be = 0; seen_we = 0;
        gnt_log.delete();
`ifdef RSV_ARB_PERF_CNT_EN
        m_if_wait = 0; m_d_wait = 0; m_xact = 0;
`endif
    endtask

    // Ends at posedge+1 with reset released; outputs must be quiet while in reset.
    task automatic do_reset();
        reset_n = 1'b0;
        if_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = '1;
        if_addr_i = $urandom; d_addr_i = $urandom; d_wdata_i = $urandom;
        d_we_i = 1; d_be_i = 4'hF;
        @(posedge clk); #1;
        check_val("reset_quiet", out_bits(), 32'h0);
        @(posedge clk); #1;
        if_req_i = 0; d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        clear_tb_state();
        reset_n = 1'b1;
    endtask

    task automatic drive_inputs();
        if (!(if_req_i && !last_if_gnt)) begin
            if (if_left > 0 && int'($urandom_range(99)) < if_pct) begin
                if_req_i  = 1;
                if_addr_i = if_fix ? if_fix_addr : $urandom;
                if_left--;
            end else begin
                if_req_i  = 0;
                if_addr_i = $urandom;
            end
        end
        if (!(d_req_i && !last_d_gnt)) begin
            if (d_left > 0 && int'($urandom_range(99)) < d_pct) begin
                d_req_i   = 1;
                d_we_i    = d_fix ? d_fix_we : 1'($urandom);
                d_be_i    = d_fix ? d_fix_be : 4'($urandom);
                d_addr_i  = d_fix ? d_fix_addr : $urandom;
                d_wdata_i = d_fix ? d_fix_wdata : $urandom;
                d_left--;
            end else begin
                d_req_i   = 0;
                d_we_i    = 1'($urandom);
                d_be_i    = 4'($urandom);
                d_addr_i  = $urandom;
                d_wdata_i = $urandom;
            end
        end
        if (m_busy && !m_granted) begin
            if (gnt_hold > 0) begin
                mem_gnt_i = 0;
                gnt_hold--;
            end else begin
                mem_gnt_i = int'($urandom_range(99)) < gnt_pct;
            end
        end else begin
            mem_gnt_i = noise && ($urandom_range(3) == 0);
        end
        mem_rdata_i = $urandom;
        if (m_busy && m_granted) begin
            if (dly_cnt == 0) begin
                mem_rvalid_i = 1;
                if (rd_fix_en) mem_rdata_i = rd_fix;
            end else begin
                mem_rvalid_i = 0;
                dly_cnt--;
            end
        end else if (late_rv > 0) begin
            mem_rvalid_i = 1;
            late_rv--;
        end else begin
            mem_rvalid_i = noise && ($urandom_range(3) == 0);
        end
    endtask

    task automatic check_outputs();
        logic        exp_req, exp_if_rv, exp_d_rv, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        exp_req = m_busy && !m_granted;
        last_rv = m_busy && m_granted && mem_rvalid_i;
        exp_if_rv = last_rv && m_own_if;
        exp_d_rv  = last_rv && !m_own_if;
        last_if_gnt = exp_req && m_own_if && mem_gnt_i;
        last_d_gnt  = exp_req && !m_own_if && mem_gnt_i;
        e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
        if (exp_req) begin
            if (m_own_if) begin
                e_be = 4'hF; e_addr = if_addr_i;
            end else begin
                e_we = d_we_i; e_be = d_be_i; e_addr = d_addr_i; e_wdata = d_wdata_i;
            end
        end
        check_val("mem_req", 32'(mem_req_o), 32'(exp_req));
        check_val("mem_we", 32'(mem_we_o), 32'(e_we));
        check_val("mem_be", 32'(mem_be_o), 32'(e_be));
        check_val("mem_addr", mem_addr_o, e_addr);
        check_val("mem_wdata", mem_wdata_o, e_wdata);
        check_val("if_gnt", 32'(if_gnt_o), 32'(last_if_gnt));
        check_val("d_gnt", 32'(d_gnt_o), 32'(last_d_gnt));
        check_val("if_rvalid", 32'(if_rvalid_o), 32'(exp_if_rv));
        check_val("d_rvalid", 32'(d_rvalid_o), 32'(exp_d_rv));
        check_val("if_rdata", if_rdata_o, exp_if_rv ? mem_rdata_i : 32'h0);
        check_val("d_rdata", d_rdata_o, exp_d_rv ? mem_rdata_i : 32'h0);
`ifdef RSV_ARB_PERF_CNT_EN
        check_val("if_wait_cnt", 32'(if_wait_cnt_o), 32'(m_if_wait));
        check_val("d_wait_cnt", 32'(d_wait_cnt_o), 32'(m_d_wait));
        check_val("xact_cnt", 32'(xact_cnt_o), 32'(m_xact));
`endif
        if (mem_req_o) begin
            seen_addr = mem_addr_o; seen_be = mem_be_o; seen_we = mem_we_o;
            seen_wdata = mem_wdata_o;
        end
        if (if_gnt_o) begin n_if_gnt++; if_gnt_cyc = cyc; gnt_log.push_back(1); end
        if (d_gnt_o) begin n_d_gnt++; d_gnt_cyc = cyc; gnt_log.push_back(0); end
        if (if_rvalid_o) begin n_if_rv++; if_rv_cyc = cyc; if_rv_data = if_rdata_o; end
        if (d_rvalid_o) begin n_d_rv++; d_rv_cyc = cyc; end
    endtask

    task automatic update_model();
        bit arb;
        arb = !m_busy || (m_granted && mem_rvalid_i);
        if (m_busy && !m_granted && mem_gnt_i) begin
            m_granted = 1;
            dly_cnt = (dly_fix >= 0) ? dly_fix : int'($urandom_range(dly_max));
        end else if (m_busy && m_granted && mem_rvalid_i) begin
            m_busy = 0;
        end
        if (arb) begin
            bit pick_if;
            pick_if = if_req_i && (!d_req_i || m_burst == MaxDBurst);
            if (if_req_i || d_req_i) begin
                m_busy = 1; m_granted = 0; m_own_if = pick_if;
            end
            m_burst = (if_req_i && !pick_if) ? m_burst + 1 : 0;
        end
`ifdef RSV_ARB_PERF_CNT_EN
        if (if_req_i && !last_if_gnt && m_if_wait != 16'hFFFF) m_if_wait++;
        if (d_req_i && !last_d_gnt && m_d_wait != 16'hFFFF) m_d_wait++;
        if (last_rv && m_xact != 16'hFFFF) m_xact++;
`endif
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            update_model();
            cyc++;
            #1;
        end
    endtask

    initial begin
        int exp_order[10];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Single fetch with zero-wait memory
        do_reset();
        if_left = 1; if_pct = 100; if_fix = 1; if_fix_addr = 32'h100;
        rd_fix_en = 1; rd_fix = 32'h0050_0093;
        run_cycles(4);
        check_val("fetch_gnt_cycle", 32'(if_gnt_cyc), 32'd1);
        check_val("fetch_rv_cycle", 32'(if_rv_cyc), 32'd2);
        check_val("fetch_rdata", if_rv_data, 32'h0050_0093);
        check_val("fetch_addr", seen_addr, 32'h100);
        check_val("fetch_be", 32'(seen_be), 32'hF);

        // Store
        do_reset();
        d_left = 1; d_pct = 100; d_fix = 1; d_fix_we = 1; d_fix_be = 4'b0011;
        d_fix_addr = 32'h2000; d_fix_wdata = 32'hDEAD_BEEF;
        run_cycles(4);
        check_val("store_we", 32'(seen_we), 32'h1);
        check_val("store_be", 32'(seen_be), 32'h3);
        check_val("store_addr", seen_addr, 32'h2000);
        check_val("store_wdata", seen_wdata, 32'hDEAD_BEEF);
        check_val("store_rvalid_cnt", 32'(n_d_rv), 32'd1);
        check_val("store_if_quiet", 32'(n_if_gnt + n_if_rv), 32'd0);

        // Continuous contention: fetch wins after MaxDBurst data grants
        do_reset();
        if_left = 100; d_left = 100; if_pct = 100; d_pct = 100;
        run_cycles(22);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("grant_order[%0d]", i),
                      (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'd99, 32'(exp_order[i]));
        end

        // Wait states: gnt held off 3 REQ cycles, rvalid 5 cycles after gnt
        do_reset();
        d_left = 1; d_pct = 100; gnt_hold = 3; dly_fix = 4; noise = 1;
        run_cycles(14);
        check_val("wait_gnt_cnt", 32'(n_d_gnt), 32'd1);
        check_val("wait_rv_cnt", 32'(n_d_rv), 32'd1);
        check_val("wait_gnt_cycle", 32'(d_gnt_cyc), 32'd4);
        check_val("wait_rv_cycle", 32'(d_rv_cyc), 32'd9);

        // Reset while waiting for the response
        do_reset();
        d_left = 1; d_pct = 100; dly_fix = 6;
        run_cycles(3);
        if_req_i = 1; d_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5_1234;
        #1;
        check_val("rsp_pre_reset_rv", 32'(d_rvalid_o), 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("rsp_reset_quiet", out_bits(), 32'h0);
        @(posedge clk); #1;
        check_val("rsp_reset_hold", out_bits(), 32'h0);
        if_req_i = 0; d_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        clear_tb_state();
        late_rv = 2;
        reset_n = 1'b1;
        run_cycles(4);
        check_val("late_rvalid_ignored", 32'(n_d_rv + n_if_rv), 32'd0);

        // Randomized traffic with noise on ignored memory handshakes
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            if_left = 1000; d_left = 1000;
            if_pct = int'($urandom_range(100, 10));
            d_pct = int'($urandom_range(100, 10));
            gnt_pct = int'($urandom_range(100, 30));
            dly_max = int'($urandom_range(4));
            noise = 1;
            run_cycles(300);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
